// File: rtl/tbird_light_decoder.sv
// rtl/tbird_light_decoder.sv - passive decoder/checker for the T-bird tail-light vector
// Optional build macro: TBIRD_HOLD_TOLERANT_EN (a repeated non-zero pattern holds state)
module tbird_light_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       y,
  input  logic             sample_en,
  input  logic             err_clr,
  output logic [1:0]       mode,
  output logic [1:0]       phase,
  output logic             seq_done,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] haz_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ, S_ERR
  } state_t;

  state_t     state, state_next, pat;
  logic       legal, done_next, err_next;
  logic [1:0] mode_next, phase_next;

  // Illegal patterns map to S_ERR, which doubles as the resync target.
  function automatic state_t match(input logic [5:0] v);
    case (v)
      6'b000000: match = S_IDLE;
      6'b001000: match = S_L1;
      6'b011000: match = S_L2;
      6'b111000: match = S_L3;
      6'b000100: match = S_R1;
      6'b000110: match = S_R2;
      6'b000111: match = S_R3;
      6'b111111: match = S_HAZ;
      default:   match = S_ERR;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    legal      = 1'b0;
    pat        = match(y);
    if (sample_en) begin
      case (state)
        S_IDLE:  legal = (pat == S_IDLE) || (pat == S_L1) || (pat == S_R1) || (pat == S_HAZ);
        S_L1:    legal = (pat == S_L2) || (pat == S_IDLE);
        S_L2:    legal = (pat == S_L3) || (pat == S_IDLE);
        S_R1:    legal = (pat == S_R2) || (pat == S_IDLE);
        S_R2:    legal = (pat == S_R3) || (pat == S_IDLE);
        default: legal = (pat == S_IDLE);
      endcase
`ifdef TBIRD_HOLD_TOLERANT_EN
      if ((state != S_IDLE) && (state != S_ERR) && (pat == state))
        legal = 1'b1;
`endif
      if (state == S_ERR) begin
        // Stay silent while the bus remains bad; only Z recovers.
        state_next = (pat == S_IDLE) ? S_IDLE : S_ERR;
      end else begin
        state_next = pat;
        err_next   = !legal;
        done_next  = legal && (pat == S_IDLE) &&
                     ((state == S_L3) || (state == S_R3) || (state == S_HAZ));
      end
    end
  end

  always_comb begin
    mode_next  = 2'd0;
    phase_next = 2'd0;
    case (state_next)
      S_L1:    begin mode_next = 2'd1; phase_next = 2'd1; end
      S_L2:    begin mode_next = 2'd1; phase_next = 2'd2; end
      S_L3:    begin mode_next = 2'd1; phase_next = 2'd3; end
      S_R1:    begin mode_next = 2'd2; phase_next = 2'd1; end
      S_R2:    begin mode_next = 2'd2; phase_next = 2'd2; end
      S_R3:    begin mode_next = 2'd2; phase_next = 2'd3; end
      S_HAZ:   begin mode_next = 2'd3; phase_next = 2'd3; end
      default: begin mode_next = 2'd0; phase_next = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode       <= 2'd0;
      phase      <= 2'd0;
      seq_done   <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      left_cnt   <= '0;
      right_cnt  <= '0;
      haz_cnt    <= '0;
    end else begin
      state    <= state_next;
      mode     <= mode_next;
      phase    <= phase_next;
      seq_done <= done_next;
      err      <= err_next;
      // A fresh error outranks a simultaneous clear.
      if (err_next)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
      if (done_next && (state == S_L3) && (left_cnt != '1))
        left_cnt <= left_cnt + 1'b1;
      if (done_next && (state == S_R3) && (right_cnt != '1))
        right_cnt <= right_cnt + 1'b1;
      if (done_next && (state == S_HAZ) && (haz_cnt != '1))
        haz_cnt <= haz_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tbird_light_decoder.sv
// tb/tb_tbird_light_decoder.sv - self-checking bench for tbird_light_decoder
// Honours TBIRD_HOLD_TOLERANT_EN when compiled with it.
module tb_tbird_light_decoder;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TBIRD_HOLD_TOLERANT_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       y = 6'd0;
  logic             sample_en = 1'b0;
  logic             err_clr = 1'b0;
  logic [1:0]       mode, phase;
  logic             seq_done, err, err_sticky;
  logic [CNT_W-1:0] left_cnt, right_cnt, haz_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: lamp-count view of the bus
  int m_mode, m_phase, m_left, m_right, m_haz;
  bit m_in_err, m_sticky, e_done, e_err;

  tbird_light_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .y(y), .sample_en(sample_en), .err_clr(err_clr),
    .mode(mode), .phase(phase), .seq_done(seq_done), .err(err),
    .err_sticky(err_sticky), .left_cnt(left_cnt), .right_cnt(right_cnt), .haz_cnt(haz_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  task automatic classify(input logic [5:0] v, output bit lg, output int md, output int ph);
    lg = 1'b1; md = 0; ph = 0;
    if (v == 6'd0) begin
      md = 0;
    end else if (v == 6'h3f) begin
      md = 3; ph = 3;
    end else if (v[2:0] == 3'd0 && (v[5:3] == 3'd1 || v[5:3] == 3'd3 || v[5:3] == 3'd7)) begin
      md = 1; ph = $countones(v[5:3]);
    end else if (v[5:3] == 3'd0 && (v[2:0] == 3'd4 || v[2:0] == 3'd6 || v[2:0] == 3'd7)) begin
      md = 2; ph = $countones(v[2:0]);
    end else begin
      lg = 1'b0;
    end
  endtask

  function automatic logic [5:0] pattern_of(input int md, input int ph);
    logic [2:0] side;
    if (md == 3) return 6'h3f;
    if (md == 1) begin side = 3'((1 << ph) - 1); return {side, 3'b000}; end
    if (md == 2) begin side = 3'(8 - (1 << (3 - ph))); return {3'b000, side}; end
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_left = 0; m_right = 0; m_haz = 0;
    m_in_err = 0; m_sticky = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step(input logic [5:0] v, input bit en, input bit clr);
    bit lg, ok;
    int nm, np;
    e_done = 0; e_err = 0;
    if (en) begin
      classify(v, lg, nm, np);
      if (m_in_err) begin
        if (v == 6'd0) m_in_err = 0;
      end else begin
        if (m_mode == 0)
          ok = lg && (nm == 0 || nm == 3 || np == 1);
        else if (v == 6'd0)
          ok = 1'b1;
        else
          ok = lg && nm == m_mode && (np == m_phase + 1 || (HOLD_OK && np == m_phase));
        if (ok && v == 6'd0 && m_phase == 3) begin
          e_done = 1;
          if (m_mode == 1 && m_left < CMAX) m_left++;
          if (m_mode == 2 && m_right < CMAX) m_right++;
          if (m_mode == 3 && m_haz < CMAX) m_haz++;
        end
        if (!ok) e_err = 1;
        if (ok || lg) begin
          m_mode = nm; m_phase = np;
        end else begin
          m_in_err = 1; m_mode = 0; m_phase = 0;
        end
      end
    end
    if (e_err) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  task automatic step(input logic [5:0] v, input bit en, input bit clr);
    @(negedge clk);
    y = v; sample_en = en; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, en, clr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mode, phase, seq_done, err, err_sticky} !== 7'd0 ||
        {left_cnt, right_cnt, haz_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mode=%0d phase=%0d cnts=%0d/%0d/%0d, wanted all 0",
               mode, phase, left_cnt, right_cnt, haz_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(6'd0, 1, 0);
      checks++;
      if (mode !== 2'd0 || phase !== 2'd0 || err !== 1'b0 || left_cnt !== '0 || haz_cnt !== '0) begin
        errors++;
        $display("FAIL idle_z: mode=%0d phase=%0d err=%0d, wanted 0 0 0", mode, phase, err);
      end
    end
  endtask

  task automatic test_left();
    logic [5:0] seq [3] = '{6'b001000, 6'b011000, 6'b111000};
    for (int i = 0; i < 3; i++) begin
      step(seq[i], 1, 0);
      checks++;
      if (mode !== 2'd1 || phase !== 2'(i + 1) || seq_done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL left_phase%0d: mode=%0d phase=%0d done=%0d err=%0d, wanted 1 %0d 0 0",
                 i + 1, mode, phase, seq_done, err, i + 1);
      end
    end
    step(6'd0, 1, 0);
    checks++;
    if (seq_done !== 1'b1 || left_cnt !== 2'd1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL left_done: done=%0d left_cnt=%0d mode=%0d, wanted 1 1 0", seq_done, left_cnt, mode);
    end
  endtask

  task automatic test_hazard();
    for (int i = 0; i < 3; i++) begin
      step(6'h3f, 1, 0);
      checks++;
      if (mode !== 2'd3 || phase !== 2'd3 || err !== 1'b0) begin
        errors++;
        $display("FAIL haz_on%0d: mode=%0d phase=%0d err=%0d, wanted 3 3 0", i, mode, phase, err);
      end
      step(6'd0, 1, 0);
      checks++;
      if (seq_done !== 1'b1 || err !== 1'b0 || haz_cnt !== 2'(i + 1)) begin
        errors++;
        $display("FAIL haz_off%0d: done=%0d err=%0d haz_cnt=%0d, wanted 1 0 %0d", i, seq_done, err, haz_cnt, i + 1);
      end
    end
  endtask

  task automatic test_resync();
    step(6'b000100, 1, 0);
    step(6'b000111, 1, 0);
    checks++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || mode !== 2'd2 || phase !== 2'd3) begin
      errors++;
      $display("FAIL resync_r3: err=%0d sticky=%0d mode=%0d phase=%0d, wanted 1 1 2 3", err, err_sticky, mode, phase);
    end
    step(6'd0, 1, 0);
    checks++;
    if (seq_done !== 1'b1 || right_cnt !== 2'd1 || err !== 1'b0 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL resync_done: done=%0d right_cnt=%0d err=%0d sticky=%0d, wanted 1 1 0 1",
               seq_done, right_cnt, err, err_sticky);
    end
    step(6'd0, 0, 1);
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: sticky=%0d, wanted 0", err_sticky);
    end
  endtask

  task automatic test_illegal_and_reset();
    step(6'b101010, 1, 0);
    checks++;
    if (err !== 1'b1 || mode !== 2'd0 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL illegal_first: err=%0d mode=%0d sticky=%0d, wanted 1 0 1", err, mode, err_sticky);
    end
    step(6'b101010, 1, 0);
    checks++;
    if (err !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL illegal_repeat: err=%0d mode=%0d, wanted 0 0", err, mode);
    end
    step(6'b001000, 1, 1);
    checks++;
    if (err !== 1'b0 || mode !== 2'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_hold_legal: err=%0d mode=%0d sticky=%0d, wanted 0 0 0", err, mode, err_sticky);
    end
    step(6'd0, 1, 0);
    step(6'b001000, 1, 0);
    step(6'b011000, 1, 0);
    checks++;
    if (mode !== 2'd1 || phase !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_l2: mode=%0d phase=%0d, wanted 1 2", mode, phase);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mode, phase, seq_done, err, err_sticky} !== 7'd0 || {left_cnt, right_cnt, haz_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: mode=%0d phase=%0d cnts=%0d/%0d/%0d, wanted all 0",
               mode, phase, left_cnt, right_cnt, haz_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    logic [5:0] seq [4] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 4; i++) step(seq[i], 1, 0);
      checks++;
      if (left_cnt !== 2'((k < CMAX) ? k : CMAX) || seq_done !== 1'b1) begin
        errors++;
        $display("FAIL sat_left%0d: left_cnt=%0d done=%0d, wanted %0d 1",
                 k, left_cnt, seq_done, (k < CMAX) ? k : CMAX);
      end
    end
  endtask

  task automatic test_hold();
    step(6'b001000, 1, 0);
    step(6'b011000, 1, 0);
    step(6'b011000, 1, 0);
    checks++;
    if (err !== !HOLD_OK || mode !== 2'd1 || phase !== 2'd2) begin
      errors++;
      $display("FAIL hold_repeat: err=%0d mode=%0d phase=%0d, wanted %0d 1 2", err, mode, phase, !HOLD_OK);
    end
    step(6'd0, 1, 0);
    checks++;
    if (seq_done !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL hold_abort: done=%0d mode=%0d, wanted 0 0", seq_done, mode);
    end
    step(6'd0, 0, 1);
  endtask

  task automatic test_random();
    logic [5:0] v;
    int r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if (m_mode == 1 || m_mode == 2)
          v = (m_phase < 3 && $urandom_range(0, 4) != 0) ? pattern_of(m_mode, m_phase + 1) : 6'd0;
        else if (m_mode == 3)
          v = 6'd0;
        else
          case ($urandom_range(0, 3))
            0: v = 6'b001000;
            1: v = 6'b000100;
            2: v = 6'h3f;
            default: v = 6'd0;
          endcase
      end else if (r < 8) begin
        v = pattern_of($urandom_range(0, 3), $urandom_range(1, 3));
      end else begin
        v = 6'($urandom);
      end
      step(v, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
      checks++;
      if (mode !== 2'(m_mode) || phase !== 2'(m_phase) || seq_done !== e_done || err !== e_err ||
          err_sticky !== m_sticky || left_cnt !== CNT_W'(m_left) ||
          right_cnt !== CNT_W'(m_right) || haz_cnt !== CNT_W'(m_haz)) begin
        errors++;
        $display("FAIL random%0d y=%b: got m%0d p%0d d%0d e%0d s%0d c%0d/%0d/%0d, wanted m%0d p%0d d%0d e%0d s%0d c%0d/%0d/%0d",
                 n, v, mode, phase, seq_done, err, err_sticky, left_cnt, right_cnt, haz_cnt,
                 m_mode, m_phase, e_done, e_err, m_sticky, m_left, m_right, m_haz);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left();
    test_hazard();
    test_resync();
    test_illegal_and_reset();
    test_saturation();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbird_light_decoder.md
Name: tbird_light_decoder

Overview:
- Monitors the 6-bit tail-light vector driven by the turn-signal FSM and decodes it back into mode, phase and sequence-completion events.
- Checks every sampled pattern against the legal left, right and hazard sequences and flags protocol violations.
- Sits on the FSM output bus as a passive reader.
- Used by lab benches and by the board-level status display.

Parameters:
- CNT_W, 8, width of each saturating completed-sequence counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- y  input  6  light vector; y[5:3]={LC,LB,LA}, y[2:0]={RA,RB,RC}.
- sample_en  input  1  y is evaluated only on edges where this is 1.
- err_clr  input  1  synchronous clear of err_sticky.
- mode  output  2  0=IDLE, 1=LEFT, 2=RIGHT, 3=HAZARD.
- phase  output  2  lamps lit in current sequence, 0-3 (hazard reports 3).
- seq_done  output  1  one-cycle pulse when a full sequence completes.
- err  output  1  one-cycle pulse on an illegal sample.
- err_sticky  output  1  set by err; cleared by err_clr or reset.
- left_cnt  output  CNT_W  completed left sequences, saturating.
- right_cnt  output  CNT_W  completed right sequences, saturating.
- haz_cnt  output  CNT_W  completed hazard flashes, saturating.

Behaviour:
- Reset (async, high): state=IDLE; all outputs 0.
- All outputs registered. A decision on sample at edge N is visible after edge N.
- sample_en=0: state and counters hold; seq_done and err are 0.
- Patterns: L1=001000, L2=011000, L3=111000, R1=000100, R2=000110, R3=000111, H=111111, Z=000000.
- States: IDLE, L1, L2, L3, R1, R2, R3, HAZ, ERR.
- Legal transitions (per sampled edge):
  - IDLE: Z->IDLE; L1->L1; R1->R1; H->HAZ.
  - L1: L2->L2; Z->IDLE (abort, no seq_done).
  - L2: L3->L3; Z->IDLE (abort, no seq_done).
  - L3: Z->IDLE, seq_done=1, left_cnt+1.
  - R1/R2/R3: mirror of left; right_cnt increments on R3->Z.
  - HAZ: Z->IDLE, seq_done=1, haz_cnt+1.
- Any other sample: err=1 and err_sticky=1.
  - Next state is the one matching y if y is a legal pattern (resync).
  - Otherwise next state is ERR.
- ERR: stays until Z is sampled, then goes to IDLE. No further err pulses while y remains illegal.
- mode/phase encoding:
  - IDLE and ERR: mode 0, phase 0.
  - Ln: mode 1, phase n. Rn: mode 2, phase n. HAZ: mode 3, phase 3.
- Counters saturate at all-ones; increment is suppressed there.
- err_clr and a new err on the same edge: set wins (err_sticky=1).
- Reset mid-sequence: returns to IDLE immediately; counters are cleared.

Optional Feature:
- Macro: TBIRD_HOLD_TOLERANT_EN.
- Defined:
  - A non-zero pattern sampled again in its own state (same y twice in a row) is legal and holds state.
  - Supports an FSM clocked slower than sample_en.
- Undefined:
  - The repeat is illegal: err pulses and the block resyncs to the same state.
  - Z repeated in IDLE is legal in both builds.

Test Plan:
1. Reset=1 for 2 cycles, then sample_en=1 with y=000000 for 3 cycles -> mode=0, phase=0, all counters 0, err never pulses.
2. Sample y=001000, 011000, 111000, 000000 -> phase 1,2,3 with mode=1; seq_done pulses once on the Z sample; left_cnt=1.
3. Sample y=111111 then 000000 three times -> mode=3, phase=3 on each H; haz_cnt=3; err=0 throughout.
4. Sample y=000100 then 000111 -> err pulses, err_sticky=1, state resyncs to R3. Next sample 000000 -> seq_done pulses, right_cnt=1. Then err_clr=1 -> err_sticky=0.
5. Sample y=101010 then y=101010 again -> exactly one err pulse, mode=0; then 000000 -> IDLE. Also assert reset mid-L2 -> all outputs 0 immediately (async).
6. With CNT_W=2, run 5 left sequences -> left_cnt saturates at 3. Separately, repeat y=011000 twice from L2 -> err=1 without TBIRD_HOLD_TOLERANT_EN, err=0 with it.
